mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255: cycles a granted transaction may wait for cbus ready before bus_err is raised.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: one clock; reset is asynchronous and active-low (reset=0 clears all state immediately).
REQ-004 SHALL have port ireq, input, ibus_req_t: core fetch request (valid, addr[63:0]).
REQ-005 SHALL have port iresp, output, ibus_resp_t: fetch response (addr_ok, data_ok, data[31:0]).
REQ-006 SHALL have port dreq, input, dbus_req_t: core data request (valid, addr, size[2:0], strobe[7:0], data[63:0]); strobe==0 is a read.
REQ-007 SHALL have port dresp, output, dbus_resp_t: data response (addr_ok, data_ok, data[63:0]).
REQ-008 SHALL have port creq, output, cbus_req_t: single-beat memory request (valid, is_write, size, addr, strobe, data).
REQ-009 SHALL have port cresp, input, cbus_resp_t: memory response (ready, last, data[63:0]).
REQ-010 SHALL have port bus_err, output, 1: sticky watchdog error flag.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY_I, BUSY_D; reset state IDLE.
REQ-012 In IDLE with dreq.valid, SHALL latch dreq and enter BUSY_D next cycle; else with ireq.valid, SHALL latch ireq and enter BUSY_I.
REQ-013 In BUSY_x, creq.valid SHALL be 1 and creq fields SHALL equal the latched request, held stable until completion.
REQ-014 For BUSY_I, creq SHALL be is_write=0, size=MSIZE4, strobe=0, addr=latched ireq.addr.
REQ-015 For BUSY_D, creq.is_write SHALL be (strobe!=0); size/addr/strobe/data from latched dreq.
REQ-016 Completion SHALL be cresp.ready&&cresp.last in BUSY_x; same cycle, owning master's addr_ok and data_ok SHALL be 1 for exactly that cycle, data combinationally from cresp.data (iresp.data = cresp.data[31:0] when addr[2]=0, [63:32] when addr[2]=1).
REQ-017 After completion, SHALL return to IDLE; one IDLE cycle separates consecutive transactions.
REQ-018 Minimum latency: request valid at cycle N, creq.valid at N+1, data_ok at N+1 if ready at N+1.
REQ-019 Non-owning master's addr_ok/data_ok SHALL remain 0 throughout.
REQ-020 Master valid dropping mid-transaction SHALL NOT abort; transaction completes and data_ok still pulses.
REQ-021 cresp.ready without last SHALL be ignored (stay BUSY).
REQ-022 Wait counter (8-bit min, saturating) SHALL clear on grant, increment each BUSY cycle without completion; reaching MAX_WAIT SHALL set bus_err, which stays 1 until reset; transaction continues waiting.
REQ-023 cresp inputs in IDLE SHALL be ignored.

Reset
REQ-024 On reset=0: state IDLE, latched requests 0, counter 0, creq all 0, iresp/dresp addr_ok=data_ok=0, bus_err=0.
REQ-025 Reset mid-transaction SHALL drop creq.valid asynchronously; no response is issued for the aborted transaction.

Configuration
REQ-026 Macro ARB_ROUND_ROBIN_EN: defined, when both valid in IDLE, grant SHALL alternate, starting with data after reset, toggling a last-grant bit on each grant; undefined, data SHALL always win (fixed priority, no last-grant bit).

Structure
REQ-027 ibus/dbus/cbus typedefs, msize_t, and arb_state_t (IDLE/BUSY_I/BUSY_D) SHALL live in the shared common package.
REQ-028 Watchdog SHALL be sub-module arb_watchdog (inputs clk, reset, clr, busy, done; output bus_err).

Verification
REQ-029 Read-only fetch: ireq.valid, addr=0x8000_0004, ready/last one cycle later with data=0x11223344_55667788 -> iresp.data_ok one cycle, data=0x11223344.
REQ-030 Simultaneous: ireq and dreq (read 0x8000_1000) valid cycle 0 -> BUSY_D first, data_ok to dresp; ibus granted after next IDLE; with ARB_ROUND_ROBIN_EN, next tie goes to ibus.
REQ-031 Store: dreq strobe=0x0F, data=0xDEAD_BEEF, size=MSIZE4 -> creq.is_write=1, fields held stable over 5 cycles of ready=0, dresp.data_ok on ready&last.
REQ-032 Watchdog: MAX_WAIT=4, no ready for 6 cycles -> bus_err=1 at 4th BUSY cycle, remains 1 after completion.
REQ-033 Reset asserted in BUSY_I mid-wait -> creq.valid=0 immediately, no data_ok, IDLE on release; next request served normally.
REQ-034 ready=1,last=0 for 3 cycles then last=1 -> single data_ok only on last cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data-to-memory arbiter: core-side bus structs,
// the single-beat memory bus, access sizes and the arbiter state encoding.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  // Plain constants rather than an enum so legacy tools can share the encoding.
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE   = 2'd0;
  localparam arb_state_t BUSY_I = 2'd1;
  localparam arb_state_t BUSY_D = 2'd2;

  // A fetch returns one 32-bit word out of the 64-bit beat, picked by addr[2].
  function automatic logic [31:0] fetch_word(input logic hi, input logic [63:0] beat);
    return hi ? beat[63:32] : beat[31:0];
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Watchdog for the arbiter: counts busy cycles that did not complete and
// raises a sticky bus_err once the count reaches MAX_WAIT.
module arb_watchdog #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic busy,
  input  logic done,
  output logic bus_err
);

  localparam int unsigned    CntW   = (MAX_WAIT > 255) ? $clog2(MAX_WAIT + 1) : 8;
  localparam logic [CntW-1:0] CntMax = '1;
  localparam logic [CntW-1:0] Limit  = CntW'(MAX_WAIT);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            inc, hit;

  // Saturating wait count; the error shows in the very cycle the limit is reached.
  always_comb begin
    inc   = busy && !done;
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
    hit   = inc && (cnt_d >= Limit);
    err_d = err_q | hit;
  end

  assign bus_err = err_q | hit;

  // Counter and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates core fetch and data requests onto one single-beat memory bus.
// Data wins ties by default; define ARB_ROUND_ROBIN_EN to alternate tie grants
// (data first after reset).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp,
  output logic       bus_err
);

  arb_state_t state_q, state_d;
  cbus_req_t  creq_q, creq_d;
  logic       pick_d, grant, done, busy;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_q, rr_d;  // set: ibus wins the next tie

  // Data wins a tie unless the last-grant bit says it is the fetch side's turn.
  always_comb begin
    pick_d = dreq.valid && !(ireq.valid && rr_q);
  end

  // Last-grant bit flips on every grant.
  always_comb begin
    rr_d = rr_q ^ grant;
  end

  // Last-grant register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  // Fixed priority: data always wins.
  always_comb begin
    pick_d = dreq.valid;
  end
`endif

  assign busy = (state_q != IDLE);
  assign done = busy && cresp.ready && cresp.last;

  // Grant in IDLE by latching the memory request itself; drop it on completion.
  always_comb begin
    state_d = state_q;
    creq_d  = creq_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          grant           = 1'b1;
          state_d         = BUSY_D;
          creq_d.valid    = 1'b1;
          creq_d.is_write = |dreq.strobe;
          creq_d.size     = dreq.size;
          creq_d.addr     = dreq.addr;
          creq_d.strobe   = dreq.strobe;
          creq_d.data     = dreq.data;
        end else if (ireq.valid) begin
          grant           = 1'b1;
          state_d         = BUSY_I;
          creq_d          = '0;
          creq_d.valid    = 1'b1;
          creq_d.size     = MSIZE4;
          creq_d.addr     = ireq.addr;
        end
      end
      BUSY_I, BUSY_D: begin
        if (done) begin
          state_d = IDLE;
          creq_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        creq_d  = '0;
      end
    endcase
  end

  // State and latched request; reset clears creq at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      creq_q  <= '0;
    end else begin
      state_q <= state_d;
      creq_q  <= creq_d;
    end
  end

  assign creq = creq_q;

  // Only the owning master sees the completion pulse and the returned data.
  always_comb begin
    iresp = '0;
    dresp = '0;
    if (state_q == BUSY_I) begin
      iresp.addr_ok = done;
      iresp.data_ok = done;
      iresp.data    = fetch_word(creq_q.addr[2], cresp.data);
    end
    if (state_q == BUSY_D) begin
      dresp.addr_ok = done;
      dresp.data_ok = done;
      dresp.data    = cresp.data;
    end
  end

  arb_watchdog #(
    .MAX_WAIT(MAX_WAIT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (grant),
    .busy   (busy),
    .done   (done),
    .bus_err(bus_err)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned MaxWait = 4;

  logic       clk;
  logic       reset;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;
  logic       bus_err;

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter #(
    .MAX_WAIT(MaxWait)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .ireq   (ireq),
    .iresp  (iresp),
    .dreq   (dreq),
    .dresp  (dresp),
    .creq   (creq),
    .cresp  (cresp),
    .bus_err(bus_err)
  );

  typedef struct {
    logic        is_d;
    logic [63:0] addr;
    logic [7:0]  strobe;
    msize_t      size;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          waits;
    logic        exp_write;
    msize_t      exp_size;
    logic [63:0] exp_data;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_creq(input string name, input cbus_req_t exp);
    n_cmp++;
    if (creq !== exp) begin
      n_bad++;
      $display("FAIL %s: got v=%b w=%b sz=%0d a=%h s=%h d=%h, want v=%b w=%b sz=%0d a=%h s=%h d=%h",
               name, creq.valid, creq.is_write, creq.size, creq.addr, creq.strobe, creq.data,
               exp.valid, exp.is_write, exp.size, exp.addr, exp.strobe, exp.data);
    end
  endtask

  function automatic cbus_req_t fetch_creq(input logic [63:0] a);
    cbus_req_t c;
    c       = '0;
    c.valid = 1'b1;
    c.size  = MSIZE4;
    c.addr  = a;
    return c;
  endfunction

  function automatic cbus_req_t data_creq(input dbus_req_t r);
    cbus_req_t c;
    c.valid    = 1'b1;
    c.is_write = (r.strobe != 8'h0);
    c.size     = r.size;
    c.addr     = r.addr;
    c.strobe   = r.strobe;
    c.data     = r.data;
    return c;
  endfunction

  task automatic idle_inputs();
    ireq  = '0;
    dreq  = '0;
    cresp = '0;
  endtask

  task automatic set_resp(input logic r, input logic l, input logic [63:0] d);
    cresp.ready = r;
    cresp.last  = l;
    cresp.data  = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    #1;
    chk_creq("rst creq", '0);
    chk("rst iresp ok", {iresp.addr_ok, iresp.data_ok}, 0);
    chk("rst dresp ok", {dresp.addr_ok, dresp.data_ok}, 0);
    chk("rst bus_err", bus_err, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One table transaction: request in IDLE, waits, then completion.
  task automatic run_txn(input vec_t v, input int idx);
    string     tag;
    cbus_req_t ec;
    logic      fin;
    tag         = $sformatf("vec%0d", idx);
    ec.valid    = 1'b1;
    ec.is_write = v.exp_write;
    ec.size     = v.exp_size;
    ec.addr     = v.addr;
    ec.strobe   = v.strobe;
    ec.data     = v.wdata;
    @(negedge clk);
    idle_inputs();
    if (v.is_d) begin
      dreq.valid  = 1'b1;
      dreq.addr   = v.addr;
      dreq.size   = v.size;
      dreq.strobe = v.strobe;
      dreq.data   = v.wdata;
    end else begin
      ireq.valid = 1'b1;
      ireq.addr  = v.addr;
    end
    #4;
    chk({tag, " idle creq.valid"}, creq.valid, 0);
    for (int k = 0; k <= v.waits; k++) begin
      @(negedge clk);
      ireq.valid = 1'b0;
      dreq.valid = 1'b0;
      dreq.data  = ~v.wdata;
      fin        = (k == v.waits);
      set_resp(fin, fin, v.rdata);
      #4;
      chk_creq($sformatf("%s creq c%0d", tag, k), ec);
      if (v.is_d) begin
        chk($sformatf("%s dresp ok c%0d", tag, k), {dresp.addr_ok, dresp.data_ok}, {2{fin}});
        chk($sformatf("%s iresp ok c%0d", tag, k), {iresp.addr_ok, iresp.data_ok}, 0);
        if (fin) chk({tag, " dresp.data"}, dresp.data, v.exp_data);
      end else begin
        chk($sformatf("%s iresp ok c%0d", tag, k), {iresp.addr_ok, iresp.data_ok}, {2{fin}});
        chk($sformatf("%s dresp ok c%0d", tag, k), {dresp.addr_ok, dresp.data_ok}, 0);
        if (fin) chk({tag, " iresp.data"}, iresp.data, v.exp_data);
      end
    end
    @(negedge clk);
    idle_inputs();
    #4;
    chk({tag, " after creq.valid"}, creq.valid, 0);
    chk({tag, " bus_err"}, bus_err, 0);
  endtask

  // Random-phase reference model state.
  logic        m_busy;
  logic        m_own_d;
  cbus_req_t   m_req;
  int unsigned m_wait;
  logic        m_err;
  logic        m_pref_i;

  initial begin : watchdog_timer
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic        second_is_d;
    logic        done_m, take_d, exp_i, exp_d, ex_err;
    logic [63:0] beat;
    dbus_req_t   st;

    reset = 1'b0;
    idle_inputs();

    tbl[0] = '{is_d: 1'b0, addr: 64'h8000_0004, strobe: 8'h00, size: MSIZE4, wdata: 64'h0,
               rdata: 64'h1122_3344_5566_7788, waits: 0, exp_write: 1'b0, exp_size: MSIZE4,
               exp_data: 64'h1122_3344};
    tbl[1] = '{is_d: 1'b0, addr: 64'h8000_0010, strobe: 8'h00, size: MSIZE4, wdata: 64'h0,
               rdata: 64'hAABB_CCDD_0102_0304, waits: 2, exp_write: 1'b0, exp_size: MSIZE4,
               exp_data: 64'h0102_0304};
    tbl[2] = '{is_d: 1'b1, addr: 64'h8000_1000, strobe: 8'h00, size: MSIZE8, wdata: 64'h0,
               rdata: 64'h0123_4567_89AB_CDEF, waits: 1, exp_write: 1'b0, exp_size: MSIZE8,
               exp_data: 64'h0123_4567_89AB_CDEF};
    tbl[3] = '{is_d: 1'b1, addr: 64'h8000_2000, strobe: 8'h0F, size: MSIZE4, wdata: 64'hDEAD_BEEF,
               rdata: 64'h0, waits: 3, exp_write: 1'b1, exp_size: MSIZE4, exp_data: 64'h0};
    tbl[4] = '{is_d: 1'b1, addr: 64'h8000_2004, strobe: 8'hF0, size: MSIZE4,
               wdata: 64'hCAFE_F00D_0000_0000, rdata: 64'h5555, waits: 0, exp_write: 1'b1,
               exp_size: MSIZE4, exp_data: 64'h5555};
    tbl[5] = '{is_d: 1'b0, addr: 64'h8000_000C, strobe: 8'h00, size: MSIZE4, wdata: 64'h0,
               rdata: 64'hFFEE_DDCC_BBAA_9988, waits: 1, exp_write: 1'b0, exp_size: MSIZE4,
               exp_data: 64'hFFEE_DDCC};

    do_reset();

    // Tie: data first; the second tie goes to ibus only with round robin.
`ifdef ARB_ROUND_ROBIN_EN
    second_is_d = 1'b0;
`else
    second_is_d = 1'b1;
`endif
    @(negedge clk);
    idle_inputs();
    ireq.valid = 1'b1;
    ireq.addr  = 64'h8000_0000;
    dreq.valid = 1'b1;
    dreq.addr  = 64'h8000_1000;
    dreq.size  = MSIZE8;
    #4;
    chk("tie idle creq.valid", creq.valid, 0);
    @(negedge clk);
    set_resp(1'b1, 1'b1, 64'h0A0B_0C0D_0E0F_1011);
    #4;
    chk("tie1 creq.addr", creq.addr, 64'h8000_1000);
    chk("tie1 dresp.data_ok", dresp.data_ok, 1);
    chk("tie1 iresp.data_ok", iresp.data_ok, 0);
    chk("tie1 dresp.data", dresp.data, 64'h0A0B_0C0D_0E0F_1011);
    @(negedge clk);
    cresp = '0;
    #4;
    chk("tie gap creq.valid", creq.valid, 0);
    @(negedge clk);
    set_resp(1'b1, 1'b1, 64'hCAFE_F00D_1234_5678);
    #4;
    chk("tie2 creq.addr", creq.addr, second_is_d ? 64'h8000_1000 : 64'h8000_0000);
    chk("tie2 dresp.data_ok", dresp.data_ok, second_is_d);
    chk("tie2 iresp.data_ok", iresp.data_ok, !second_is_d);
    @(negedge clk);
    cresp = '0;
    if (second_is_d) dreq.valid = 1'b0;
    else ireq.valid = 1'b0;
    #4;
    chk("tie gap2 creq.valid", creq.valid, 0);
    @(negedge clk);
    set_resp(1'b1, 1'b1, 64'hCAFE_F00D_1234_5678);
    #4;
    chk("tie3 creq.addr", creq.addr, second_is_d ? 64'h8000_0000 : 64'h8000_1000);
    chk("tie3 iresp.data_ok", iresp.data_ok, second_is_d);
    chk("tie3 dresp.data_ok", dresp.data_ok, !second_is_d);
    if (second_is_d) chk("tie3 iresp.data", iresp.data, 64'h1234_5678);

    for (int i = 0; i < 6; i++) run_txn(tbl[i], i);

    // Responses in IDLE are ignored; ready without last keeps waiting.
    @(negedge clk);
    idle_inputs();
    set_resp(1'b1, 1'b1, 64'h1);
    #4;
    chk("idle resp creq.valid", creq.valid, 0);
    chk("idle resp oks", {iresp.data_ok, dresp.data_ok}, 0);
    @(negedge clk);
    ireq.valid = 1'b1;
    ireq.addr  = 64'h8000_0024;
    #4;
    chk("nolast grant iresp.data_ok", iresp.data_ok, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      ireq.valid = 1'b0;
      set_resp(1'b1, k == 4, 64'h7777_8888_9999_AAAA);
      #4;
      chk($sformatf("nolast creq.valid c%0d", k), creq.valid, 1);
      chk($sformatf("nolast iresp.data_ok c%0d", k), iresp.data_ok, k == 4);
      if (k == 4) chk("nolast iresp.data", iresp.data, 64'h7777_8888);
    end
    @(negedge clk);
    idle_inputs();
    #4;
    chk("nolast end creq.valid", creq.valid, 0);
    chk("nolast bus_err", bus_err, 0);

    // Long-waiting store: fields stable, watchdog trips and sticks.
    st.valid  = 1'b1;
    st.addr   = 64'h8000_3000;
    st.size   = MSIZE4;
    st.strobe = 8'h0F;
    st.data   = 64'hDEAD_BEEF;
    @(negedge clk);
    dreq = st;
    #4;
    chk("wd grant bus_err", bus_err, 0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      dreq = '0;
      set_resp(k == 7, (k == 7) || (k % 2 == 0), 64'h0);
      #4;
      chk_creq($sformatf("wd creq c%0d", k), data_creq(st));
      chk($sformatf("wd dresp.data_ok c%0d", k), dresp.data_ok, k == 7);
      chk($sformatf("wd bus_err c%0d", k), bus_err, k >= int'(MaxWait));
    end
    @(negedge clk);
    idle_inputs();
    #4;
    chk("wd after creq.valid", creq.valid, 0);
    chk("wd sticky bus_err", bus_err, 1);

    // Reset in the middle of a fetch wait.
    @(negedge clk);
    ireq.valid = 1'b1;
    ireq.addr  = 64'h8000_0040;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      ireq.valid = 1'b0;
      #4;
      chk($sformatf("mrst creq.valid c%0d", k), creq.valid, 1);
    end
    @(negedge clk);
    set_resp(1'b1, 1'b1, 64'h9);
    reset = 1'b0;
    #1;
    chk("mrst async creq.valid", creq.valid, 0);
    chk("mrst iresp.data_ok", iresp.data_ok, 0);
    chk("mrst bus_err", bus_err, 0);
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    #4;
    chk("mrst release creq.valid", creq.valid, 0);
    run_txn(tbl[1], 10);

    // Randomized run against the transaction-level model.
    do_reset();
    m_busy   = 1'b0;
    m_own_d  = 1'b0;
    m_req    = '0;
    m_wait   = 0;
    m_err    = 1'b0;
    m_pref_i = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      ireq.valid  = ($urandom_range(0, 2) == 0);
      ireq.addr   = {$urandom, $urandom};
      dreq.valid  = ($urandom_range(0, 2) == 0);
      dreq.addr   = {$urandom, $urandom};
      dreq.size   = msize_t'($urandom_range(0, 3));
      dreq.strobe = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      dreq.data   = {$urandom, $urandom};
      cresp.ready = 1'($urandom_range(0, 1));
      cresp.last  = ($urandom_range(0, 2) != 0);
      cresp.data  = {$urandom, $urandom};
      #4;
      done_m = m_busy && cresp.ready && cresp.last;
      exp_i  = done_m && !m_own_d;
      exp_d  = done_m && m_own_d;
      ex_err = m_err || (m_busy && !done_m && (m_wait + 1 >= MaxWait));
      if (m_busy) chk_creq($sformatf("rnd creq t%0d", c), m_req);
      else chk($sformatf("rnd idle creq.valid t%0d", c), creq.valid, 0);
      chk($sformatf("rnd iresp ok t%0d", c), {iresp.addr_ok, iresp.data_ok}, {2{exp_i}});
      chk($sformatf("rnd dresp ok t%0d", c), {dresp.addr_ok, dresp.data_ok}, {2{exp_d}});
      beat = cresp.data;
      if (exp_i) begin
        chk($sformatf("rnd iresp.data t%0d", c), iresp.data,
            m_req.addr[2] ? {32'h0, beat[63:32]} : {32'h0, beat[31:0]});
      end
      if (exp_d) chk($sformatf("rnd dresp.data t%0d", c), dresp.data, beat);
      chk($sformatf("rnd bus_err t%0d", c), bus_err, ex_err);

      if (!m_busy) begin
        take_d = dreq.valid && !(ireq.valid && m_pref_i);
        if (take_d || ireq.valid) begin
          m_busy  = 1'b1;
          m_own_d = take_d;
          m_req   = take_d ? data_creq(dreq) : fetch_creq(ireq.addr);
          m_wait  = 0;
`ifdef ARB_ROUND_ROBIN_EN
          m_pref_i = !m_pref_i;
`endif
        end
      end else if (done_m) begin
        m_busy = 1'b0;
      end else begin
        m_wait++;
        if (m_wait >= MaxWait) m_err = 1'b1;
      end
    end

    @(negedge clk);
    idle_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
